merge_node_ctrl: RTL and testbench

Parametrised two-input merge node for the merge-sort tree: pops records from two sorted input FIFOs (A, B) and emits one merged sorted stream, one record per cycle. Each sorted run ends in a terminator record (key field all-zero). The node merges run pairs, emits one terminator per pair, toggles a bank-select output, and optionally stops after a fixed run count. It replaces the fixed-width control FSM and integrates the compare/select datapath and an output register.

---
 rtl/merge_node_ctrl_if.sv | 29 ++
 rtl/merge_node_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_merge_node_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/merge_node_ctrl_if.sv
// Handshake bundle for the two-input merge node: two FIFO heads in,
// one merged record stream out, plus the node's status outputs.
// The master modport is the merge node itself; slave is its environment.
interface merge_node_ctrl_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] i_a_data;
    logic              i_a_valid;
    logic              o_a_pop;
    logic [DATA_W-1:0] i_b_data;
    logic              i_b_valid;
    logic              o_b_pop;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_switch;
    logic              o_done;
    logic [31:0]       o_rec_count;

    modport master (
        input  i_a_data, i_a_valid, i_b_data, i_b_valid, i_ready,
        output o_a_pop, o_b_pop, o_data, o_valid, o_switch, o_done, o_rec_count
    );

    modport slave (
        output i_a_data, i_a_valid, i_b_data, i_b_valid, i_ready,
        input  o_a_pop, o_b_pop, o_data, o_valid, o_switch, o_done, o_rec_count
    );
endinterface

// File: rtl/merge_node_ctrl.sv
// Two-input merge node for the merge-sort tree. Merges sorted runs from FIFOs
// A and B (each run closed by a key==0 terminator) into one sorted stream,
// emits one terminator per run pair, toggles the bank select after it, and
// optionally stops after RUNS pairs.
// Optional feature: define MERGE_STATS_EN to count emitted non-terminator
// records on o_rec_count; otherwise o_rec_count is tied to zero.
module merge_node_ctrl #(
    parameter int DATA_W = 32,
    parameter int KEY_W  = 32,
    parameter int RUNS   = 0,
    parameter int CNT_W  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    merge_node_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        S_MERGE,
        S_DRAIN_A,
        S_DRAIN_B,
        S_TERM,
        S_FINISHED
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                switch_q, switch_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;

    logic [KEY_W-1:0]    a_key, b_key;
    logic                a_term, b_term;
    logic                adv;
    logic [CNT_W-1:0]    run_cnt_inc;

    logic                a_pop, b_pop;
    logic                load, load_term;
    logic [DATA_W-1:0]   load_data;

    assign a_key       = bus.i_a_data[KEY_W-1:0];
    assign b_key       = bus.i_b_data[KEY_W-1:0];
    assign a_term      = bus.i_a_valid && (a_key == '0);
    assign b_term      = bus.i_b_valid && (b_key == '0);
    // The output slot can take a record when it is empty or being drained.
    assign adv         = ~valid_q | bus.i_ready;
    assign run_cnt_inc = run_cnt_q + 1'b1;

    // Next-state, pop and output-load decision for the merge FSM.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d   = state_q;
        a_pop     = 1'b0;
        b_pop     = 1'b0;
        load      = 1'b0;
        load_term = 1'b0;
        load_data = '0;
        unique case (state_q)
            S_MERGE: begin
                if (bus.i_a_valid && bus.i_b_valid) begin
                    if (a_term && b_term) begin
                        state_d = S_TERM;
                    end else if (a_term) begin
                        state_d = S_DRAIN_A;
                    end else if (b_term) begin
                        state_d = S_DRAIN_B;
                    end else if (adv) begin
                        load = 1'b1;
                        // Ties go to A so equal keys keep their input order.
                        if (a_key <= b_key) begin
                            a_pop     = 1'b1;
                            load_data = bus.i_a_data;
                        end else begin
                            b_pop     = 1'b1;
                            load_data = bus.i_b_data;
                        end
                    end
                end
            end
            S_DRAIN_A: begin
                if (bus.i_b_valid) begin
                    if (b_term) begin
                        state_d = S_TERM;
                    end else if (adv) begin
                        b_pop     = 1'b1;
                        load      = 1'b1;
                        load_data = bus.i_b_data;
                    end
                end
            end
            S_DRAIN_B: begin
                if (bus.i_a_valid) begin
                    if (a_term) begin
                        state_d = S_TERM;
                    end else if (adv) begin
                        a_pop     = 1'b1;
                        load      = 1'b1;
                        load_data = bus.i_a_data;
                    end
                end
            end
            S_TERM: begin
                // Both terminators leave together as a single all-zero record.
                if (a_term && b_term && adv) begin
                    a_pop     = 1'b1;
                    b_pop     = 1'b1;
                    load      = 1'b1;
                    load_term = 1'b1;
                    load_data = '0;
                    if ((RUNS != 0) && (run_cnt_inc == CNT_W'(RUNS)))
                        state_d = S_FINISHED;
                    else
                        state_d = S_MERGE;
                end
            end
            S_FINISHED: begin
                state_d = S_FINISHED;
            end
            default: begin
                state_d = S_MERGE;
            end
        endcase
    end

    // Next values for the output register, bank select, run counter and done flag.
    always_comb begin
        data_d    = load ? load_data : data_q;
        valid_d   = load ? 1'b1 : (bus.i_ready ? 1'b0 : valid_q);
        switch_d  = switch_q ^ load_term;
        run_cnt_d = load_term ? run_cnt_inc : run_cnt_q;
        done_d    = done_q | (state_d == S_FINISHED);
    end

    // State and output registers; reset discards any record held in the output slot.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_MERGE;
            data_q    <= '0;
            valid_q   <= 1'b0;
            switch_q  <= 1'b0;
            done_q    <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            switch_q  <= switch_d;
            done_q    <= done_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    assign bus.o_a_pop  = a_pop;
    assign bus.o_b_pop  = b_pop;
    assign bus.o_data   = data_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_switch = switch_q;
    assign bus.o_done   = done_q;

`ifdef MERGE_STATS_EN
    logic [31:0] rec_cnt_q, rec_cnt_d;

    // Saturating count of non-terminator records loaded into the output slot.
    always_comb begin
        rec_cnt_d = rec_cnt_q;
        if (load && !load_term && (rec_cnt_q != '1))
            rec_cnt_d = rec_cnt_q + 1'b1;
    end

    // Record counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            rec_cnt_q <= '0;
        else
            rec_cnt_q <= rec_cnt_d;
    end

    assign bus.o_rec_count = rec_cnt_q;
`else
    assign bus.o_rec_count = '0;
`endif

endmodule

// File: tb/tb_merge_node_ctrl.sv
// Directed bench for merge_node_ctrl: FIFO heads are modelled with queues,
// the accepted output stream is collected and compared with hand-computed
// sequences. DUT built with KEY_W=16 (upper bits carry tags) and RUNS=2.
module tb_merge_node_ctrl;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    merge_node_ctrl_if #(.DATA_W(DW)) bus ();

    merge_node_ctrl #(
        .DATA_W (DW),
        .KEY_W  (16),
        .RUNS   (2),
        .CNT_W  (4)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] outq[$];
    logic [DW-1:0] expq[$];
    logic [DW-1:0] frozen;
    int            na_pops;
    int            nb_pops;
    int            n_assert;
    int            n_fail;

    function automatic logic [31:0] rec_exp(input int n);
`ifdef MERGE_STATS_EN
        return 32'(n);
`else
        return 32'(n * 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        logic [DW-1:0] got;
        check({tag, " len"}, DW'(outq.size()), DW'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            got = (i < outq.size()) ? outq[i] : 32'hDEAD_BEEF;
            check($sformatf("%s[%0d]", tag, i), got, expq[i]);
        end
    endtask

    task automatic drive();
        bus.i_a_valid = (qa.size() != 0);
        bus.i_a_data  = (qa.size() != 0) ? qa[0] : '0;
        bus.i_b_valid = (qb.size() != 0);
        bus.i_b_data  = (qb.size() != 0) ? qb[0] : '0;
    endtask

    // Pops and output acceptance are sampled at the falling edge, applied after the rising edge.
    task automatic tick();
        logic pa, pb;
        @(negedge clk);
        pa = bus.o_a_pop;
        pb = bus.o_b_pop;
        if (bus.o_valid && bus.i_ready) outq.push_back(bus.o_data);
        @(posedge clk);
        #1;
        if (pa) begin
            na_pops++;
            if (qa.size() != 0) void'(qa.pop_front());
        end
        if (pb) begin
            nb_pops++;
            if (qb.size() != 0) void'(qb.pop_front());
        end
        drive();
    endtask

    task automatic clear_log();
        outq.delete();
        na_pops = 0;
        nb_pops = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        qa.delete();
        qb.delete();
        drive();
        bus.i_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        clear_log();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        bus.i_ready = 1'b1;
        clear_log();
        drive();

        // Reset values
        apply_reset();
        check("rst valid",  DW'(bus.o_valid),  '0);
        check("rst data",   bus.o_data,        '0);
        check("rst switch", DW'(bus.o_switch), '0);
        check("rst done",   DW'(bus.o_done),   '0);
        check("rst rec",    bus.o_rec_count,   '0);

        // Basic merge: A={3,5,0}, B={4,0}
        qa = '{32'd3, 32'd5, 32'd0};
        qb = '{32'd4, 32'd0};
        drive();
        tick();
        check("lat valid", DW'(bus.o_valid), 1);
        check("lat data",  bus.o_data,       3);
        repeat (12) tick();
        expq = '{32'd3, 32'd4, 32'd5, 32'd0};
        check_stream("basic");
        check("basic switch", DW'(bus.o_switch), 1);
        check("basic popsA",  DW'(na_pops), 3);
        check("basic popsB",  DW'(nb_pops), 2);
        check("basic done",   DW'(bus.o_done), 0);
        check("basic rec",    bus.o_rec_count, rec_exp(3));

        // Asynchronous reset while in DRAIN_A (switch is 1 from the pair above)
        clear_log();
        qa = '{32'd1, 32'd0};
        qb = '{32'd2, 32'd3, 32'd4, 32'd0};
        drive();
        repeat (3) tick();
        check("drain data", bus.o_data, 2);
        rst = 1'b1;
        qa.delete();
        qb.delete();
        drive();
        #1;
        check("arst valid",  DW'(bus.o_valid),  '0);
        check("arst data",   bus.o_data,        '0);
        check("arst switch", DW'(bus.o_switch), '0);
        check("arst rec",    bus.o_rec_count,   '0);
        repeat (2) tick();
        rst = 1'b0;
        clear_log();
        qa = '{32'd8, 32'd0};
        qb = '{32'd9, 32'd0};
        drive();
        repeat (12) tick();
        expq = '{32'd8, 32'd9, 32'd0};
        check_stream("restart");
        check("restart done", DW'(bus.o_done), 0);
        check("restart rec",  bus.o_rec_count, rec_exp(2));

        // Ties: equal keys, upper bits identify the source
        apply_reset();
        qa = '{32'h0001_0007, 32'd0};
        qb = '{32'h0002_0007, 32'd0};
        drive();
        repeat (12) tick();
        expq = '{32'h0001_0007, 32'h0002_0007, 32'd0};
        check_stream("tie");

        // Backpressure: i_ready low for 3 cycles mid-stream
        apply_reset();
        qa = '{32'd1, 32'd3, 32'd5, 32'd0};
        qb = '{32'd2, 32'd4, 32'd6, 32'd0};
        drive();
        repeat (2) tick();
        frozen = bus.o_data;
        check("bp before", frozen, 2);
        bus.i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp valid%0d", i), DW'(bus.o_valid), 1);
            check($sformatf("bp data%0d", i),  bus.o_data, frozen);
        end
        check("bp pops", DW'(na_pops + nb_pops), 2);
        bus.i_ready = 1'b1;
        repeat (15) tick();
        expq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd0};
        check_stream("bp");

        // Empty stall: B invalid for 4 cycles
        apply_reset();
        qa = '{32'd2, 32'd6, 32'd0};
        drive();
        repeat (4) tick();
        check("stall pops",  DW'(na_pops + nb_pops), 0);
        check("stall valid", DW'(bus.o_valid), 0);
        qb = '{32'd3, 32'd0};
        drive();
        repeat (12) tick();
        expq = '{32'd2, 32'd3, 32'd6, 32'd0};
        check_stream("stall");

        // RUNS=2 with three pairs offered
        apply_reset();
        qa = '{32'd1, 32'd0, 32'd5, 32'd0, 32'd9, 32'd0};
        qb = '{32'd2, 32'd0, 32'd6, 32'd0, 32'd10, 32'd0};
        drive();
        repeat (25) tick();
        expq = '{32'd1, 32'd2, 32'd0, 32'd5, 32'd6, 32'd0};
        check_stream("runs");
        check("runs done",   DW'(bus.o_done),   1);
        check("runs switch", DW'(bus.o_switch), 0);
        check("runs leftA",  DW'(qa.size()), 2);
        check("runs leftB",  DW'(qb.size()), 2);
        check("runs popsA",  DW'(na_pops), 4);
        check("runs popsB",  DW'(nb_pops), 4);
        check("runs valid",  DW'(bus.o_valid), 0);
        check("runs rec",    bus.o_rec_count, rec_exp(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
